updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 3, the counter register width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter MODULUS, default 8, the count range 0..MODULUS-1 (legal range 2..2**WIDTH).

Ports (one per line: name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port clr, input, 1, the synchronous clear.
REQ-006 The block SHALL have port load, input, 1, the synchronous parallel-load strobe.
REQ-007 The block SHALL have port load_val, input, WIDTH, the value to load.
REQ-008 The block SHALL have port en, input, 1, the count enable.
REQ-009 The block SHALL have port up_dn, input, 1, the direction select: 1 = up, 0 = down.
REQ-010 The block SHALL have port sat, input, 1, the mode select: 1 = saturate at the boundary, 0 = wrap modulo MODULUS.
REQ-011 The block SHALL have port q, output, WIDTH, the registered count value.
REQ-012 The block SHALL have port tc, output, 1, the combinational terminal-count flag.
REQ-013 The block SHALL have port wrap, output, 1, the registered one-cycle wrap pulse.
REQ-014 The block SHALL have port ovf, output, 1, the registered sticky boundary-event flag.
REQ-015 The block SHALL have port load_err, output, 1, the registered one-cycle out-of-range load pulse.

Function
REQ-016 The block SHALL apply update priority per rising clk edge as follows: clr > load > en > hold.
REQ-017 When clr=1, the block SHALL set q=0 and ovf=0.
REQ-018 When clr=1, the block SHALL set wrap=0 and load_err=0.
REQ-019 When load=1 and load_val <= MODULUS-1, the block SHALL set q=load_val and load_err=0.
REQ-020 When load=1 and load_val >= MODULUS, the block SHALL set q=MODULUS-1 and load_err=1 for exactly one cycle.
REQ-021 When en=1 and up_dn=1 and q < MODULUS-1, the block SHALL increment q by 1.
REQ-022 When en=1 and up_dn=0 and q > 0, the block SHALL decrement q by 1.
REQ-023 At the up boundary (en=1, up_dn=1, q=MODULUS-1), the block SHALL set q=0 when sat=0 and hold q when sat=1.
REQ-024 At the down boundary (en=1, up_dn=0, q=0), the block SHALL set q=MODULUS-1 when sat=0 and hold q when sat=1.
REQ-025 The block SHALL assert wrap for exactly the one cycle after an edge on which a wrap (sat=0 boundary step) occurred, and deassert it otherwise.
REQ-026 The block SHALL set ovf on any boundary step (wrap or saturate-hold), keep it set until clr or rst, and never clear it by load.
REQ-027 The block SHALL drive tc = en & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)), purely combinationally, with zero-cycle latency from en, up_dn and q.
REQ-028 When en=0 and load=0 and clr=0, the block SHALL hold q, deassert wrap and load_err, and hold ovf.
REQ-029 Direction changes SHALL take effect on the same edge with no extra latency.
REQ-030 Arithmetic SHALL be WIDTH bits wide, q SHALL never leave 0..MODULUS-1, and no intermediate result SHALL alias when MODULUS = 2**WIDTH.
REQ-031 Load and count of the same cycle SHALL NOT combine: when load=1 the block SHALL ignore en, and load SHALL NOT set wrap or ovf.

Reset
REQ-032 While rst=0, the block SHALL immediately (without waiting for clk) force q=0, wrap=0, ovf=0 and load_err=0; tc then follows REQ-027.
REQ-033 Reset deasserted mid-count SHALL resume counting from 0 on the first rising clk edge with rst=1.
REQ-034 Reset asserted in the same cycle as load or clr SHALL leave the outputs at their reset values.

Verification (WIDTH=3, MODULUS=8 unless stated)
REQ-035 The bench SHALL apply rst=0 pulse, then rst=1, en=1, up_dn=1, sat=0 for 9 edges; q SHALL be 1..7,0,1, with wrap high only in the cycle after q 7->0 and ovf=1 thereafter.
REQ-036 The bench SHALL set MODULUS=6, up_dn=0 from q=0, sat=0; q SHALL be 5,4,3,2,1,0,5, with tc=1 while q=0.
REQ-037 The bench SHALL set sat=1, up_dn=1 from q=6 for 3 edges; q SHALL be 7,7,7, with wrap=0 throughout and ovf=1 after the second edge.
REQ-038 The bench SHALL apply load=1, load_val=3 with en=1 on the same edge; q SHALL be 3 (not 4) and load_err=0. With MODULUS=6 and load_val=7, q SHALL be 5 and load_err=1 for one cycle.
REQ-039 The bench SHALL assert clr=1 together with load=1 while ovf=1; q SHALL be 0 and ovf=0.
REQ-040 The bench SHALL drive rst low asynchronously between edges while q=5; q SHALL read 0 before the next clk edge, and after rst=1 the next edge SHALL give q=1.

Source files
------------

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//   Up/down counter over the range 0..MODULUS-1. At a range boundary it
//   either wraps or saturates (hold), as selected by sat. It also supports a
//   synchronous clear and a range-checked parallel load.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   MODULUS  count range 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   clr       synchronous clear (highest priority)
//   load      synchronous load strobe; load_val is range-checked
//   load_val  value to load
//   en        count enable
//   up_dn     direction select: 1 = up, 0 = down
//   sat       boundary mode select: 1 = saturate, 0 = wrap
//   q         registered count
//   tc        combinational terminal count (the next enabled step is a
//             boundary step)
//   wrap      one-cycle pulse after a wrap step
//   ovf       sticky flag set by any boundary step; cleared by clr/rst only
//   load_err  one-cycle pulse after an out-of-range load
// ---------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int     WIDTH   = 3,
  parameter longint MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);

  // MODULUS-1 always fits in WIDTH bits, even when MODULUS == 2**WIDTH.
  // All range checks are therefore made against MAX_V, and MODULUS itself
  // is never formed in WIDTH-bit arithmetic, so no comparison can alias.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_lerr, w_lerr_nxt;
  logic             w_at_top, w_at_bot, w_bnd;

  assign w_at_top = (r_q == MAX_V);
  assign w_at_bot = (r_q == '0);
  // The step in the currently selected direction would leave the range.
  assign w_bnd    = up_dn ? w_at_top : w_at_bot;

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_ovf_nxt  = r_ovf;
    w_lerr_nxt = 1'b0;
    if (clr) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (load) begin
      // A load clamps to the top of the range and flags the error. It never
      // touches wrap or ovf, and en is ignored on a load cycle.
      if (load_val > MAX_V) begin
        w_q_nxt    = MAX_V;
        w_lerr_nxt = 1'b1;
      end else begin
        w_q_nxt = load_val;
      end
    end else if (en) begin
      if (w_bnd) begin
        w_ovf_nxt = 1'b1;
        if (!sat) begin
          w_wrap_nxt = 1'b1;
          w_q_nxt    = up_dn ? '0 : MAX_V;
        end
      end else begin
        w_q_nxt = up_dn ? (r_q + ONE) : (r_q - ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
      r_ovf  <= w_ovf_nxt;
      r_lerr <= w_lerr_nxt;
    end
  end

  assign q        = r_q;
  assign wrap     = r_wrap;
  assign ovf      = r_ovf;
  assign load_err = r_lerr;
  assign tc       = en & w_bnd;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] clr, load, en, up_dn, sat;
  logic [2:0] lv [2];
  logic [2:0] q  [2];
  logic [1:0] tc, wrap, ovf, lerr;

  // Instance 0 uses MODULUS=8 (full range), instance 1 uses MODULUS=6.
  updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u_m8 (
    .clk(clk), .rst(rst), .clr(clr[0]), .load(load[0]), .load_val(lv[0]),
    .en(en[0]), .up_dn(up_dn[0]), .sat(sat[0]), .q(q[0]), .tc(tc[0]),
    .wrap(wrap[0]), .ovf(ovf[0]), .load_err(lerr[0]));

  updown_mod_counter #(.WIDTH(3), .MODULUS(6)) u_m6 (
    .clk(clk), .rst(rst), .clr(clr[1]), .load(load[1]), .load_val(lv[1]),
    .en(en[1]), .up_dn(up_dn[1]), .sat(sat[1]), .q(q[1]), .tc(tc[1]),
    .wrap(wrap[1]), .ovf(ovf[1]), .load_err(lerr[1]));

  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  // Reference model: the count is an integer in 0..M-1; each step adds +/-1.
  // A step that leaves the range is a boundary event, resolved by modulo
  // (wrap) or by keeping the old value (saturate).
  int MM [2] = '{8, 6};
  int mq [2], mw [2], mo [2], ml [2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d] = 0; mw[d] = 0; mo[d] = 0; ml[d] = 0;
    end
  endtask

  task automatic model_step();
    int n;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        mq[d] = 0; mw[d] = 0; mo[d] = 0; ml[d] = 0;
      end else if (clr[d]) begin
        mq[d] = 0; mw[d] = 0; mo[d] = 0; ml[d] = 0;
      end else if (load[d]) begin
        mw[d] = 0;
        if (int'(lv[d]) >= MM[d]) begin mq[d] = MM[d] - 1; ml[d] = 1; end
        else begin mq[d] = int'(lv[d]); ml[d] = 0; end
      end else if (en[d]) begin
        ml[d] = 0;
        n = mq[d] + (up_dn[d] ? 1 : -1);
        if (n < 0 || n >= MM[d]) begin
          mo[d] = 1;
          mw[d] = sat[d] ? 0 : 1;
          if (!sat[d]) mq[d] = (n + MM[d]) % MM[d];
        end else begin
          mq[d] = n; mw[d] = 0;
        end
      end else begin
        mw[d] = 0; ml[d] = 0;
      end
    end
  endtask

  function automatic int model_tc(input int d);
    if (!en[d]) return 0;
    return up_dn[d] ? int'(mq[d] == MM[d] - 1) : int'(mq[d] == 0);
  endfunction

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, ".q"},    d, 32'(q[d]),    32'(mq[d]));
      chk({tag, ".wrap"}, d, 32'(wrap[d]), 32'(mw[d]));
      chk({tag, ".ovf"},  d, 32'(ovf[d]),  32'(mo[d]));
      chk({tag, ".lerr"}, d, 32'(lerr[d]), 32'(ml[d]));
      chk({tag, ".tc"},   d, 32'(tc[d]),   32'(model_tc(d)));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_all();
    clr = '0; load = '0; en = '0; up_dn = '0; sat = '0;
    lv[0] = '0; lv[1] = '0;
  endtask

  initial begin
    idle_all();
    model_reset();
    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Count up with wrap on M=8: 1..7,0,1
    en[0] = 1; up_dn[0] = 1; sat[0] = 0;
    for (int i = 1; i <= 9; i++) begin
      tick("up8");
      chk("up8.q_const",    0, 32'(q[0]),    32'(i % 8));
      chk("up8.wrap_const", 0, 32'(wrap[0]), 32'(i == 8));
      chk("up8.ovf_const",  0, 32'(ovf[0]),  32'(i >= 8));
    end

    // Count down with wrap on M=6 from 0: 5,4,3,2,1,0,5
    en[0] = 0;
    en[1] = 1; up_dn[1] = 0; sat[1] = 0;
    #1;
    chk("dn6.tc_at0", 1, 32'(tc[1]), 32'd1);
    for (int i = 0; i < 7; i++) begin
      int exp_q;
      exp_q = (i == 6) ? 5 : 5 - i;
      tick("dn6");
      chk("dn6.q_const",  1, 32'(q[1]),  32'(exp_q));
      chk("dn6.tc_const", 1, 32'(tc[1]), 32'(exp_q == 0));
    end

    // tc follows en combinationally (no edge in between)
    en[1] = 0; up_dn[1] = 1;
    load[1] = 1; lv[1] = 3'd5;   // q already 5; just hold it there
    tick("tc_prep");
    load[1] = 0;
    #1;
    chk("tc.en0", 1, 32'(tc[1]), 32'd0);
    en[1] = 1;
    #1;
    chk("tc.en1", 1, 32'(tc[1]), 32'd1);
    up_dn[1] = 0;
    #1;
    chk("tc.dn", 1, 32'(tc[1]), 32'd0);
    en[1] = 0;

    // Saturate up on M=8 from 6: 7,7,7; ovf set on the second edge
    clr[0] = 1;
    tick("sat.clr");
    clr[0] = 0; load[0] = 1; lv[0] = 3'd6;
    tick("sat.load");
    load[0] = 0; en[0] = 1; up_dn[0] = 1; sat[0] = 1;
    for (int i = 1; i <= 3; i++) begin
      tick("sat8");
      chk("sat8.q_const",    0, 32'(q[0]),    32'd7);
      chk("sat8.wrap_const", 0, 32'(wrap[0]), 32'd0);
      chk("sat8.ovf_const",  0, 32'(ovf[0]),  32'(i >= 2));
    end

    // Load beats count on the same edge; out-of-range load on M=6
    sat[0] = 0; load[0] = 1; lv[0] = 3'd3;
    load[1] = 1; lv[1] = 3'd7;
    tick("load");
    chk("load.q3",    0, 32'(q[0]),    32'd3);
    chk("load.lerr0", 0, 32'(lerr[0]), 32'd0);
    chk("load.ovf",   0, 32'(ovf[0]),  32'd1);
    chk("load.q5",    1, 32'(q[1]),    32'd5);
    chk("load.lerr1", 1, 32'(lerr[1]), 32'd1);
    load = '0; en = '0;
    tick("load.after");
    chk("load.lerr_pulse", 1, 32'(lerr[1]), 32'd0);

    // Clear beats load while ovf is set
    clr[0] = 1; load[0] = 1; lv[0] = 3'd4;
    tick("clr");
    chk("clr.q",   0, 32'(q[0]),   32'd0);
    chk("clr.ovf", 0, 32'(ovf[0]), 32'd0);
    clr[0] = 0; load[0] = 0;

    // Asynchronous reset between edges while q=5
    load[0] = 1; lv[0] = 3'd5;
    tick("ar.load");
    load[0] = 0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("ar.q_async", 0, 32'(q[0]), 32'd0);
    check_all("ar.async");
    load[0] = 1; lv[0] = 3'd6; clr[1] = 1;
    tick("ar.held");
    chk("ar.q_held", 0, 32'(q[0]), 32'd0);
    rst = 1'b1;
    load = '0; clr = '0;
    en[0] = 1; up_dn[0] = 1;
    tick("ar.resume");
    chk("ar.q_resume", 0, 32'(q[0]), 32'd1);

    // Randomized traffic on both instances against the model
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        clr[d]   = ($urandom_range(0, 31) == 0);
        load[d]  = ($urandom_range(0, 9) == 0);
        lv[d]    = 3'($urandom_range(0, 7));
        en[d]    = ($urandom_range(0, 3) != 0);
        up_dn[d] = ($urandom_range(0, 3) != 0) ^ (c[7]);
        sat[d]   = ($urandom_range(0, 5) == 0);
      end
      #1;
      for (int d = 0; d < 2; d++)
        chk("rnd.tc_pre", d, 32'(tc[d]), 32'(model_tc(d)));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
